// File: rtl/vscale_prng_if.sv
// Seed-load and random-word handshake bundle between the PRNG and its
// controller/consumer. The consumer side uses the master modport.
`timescale 1ns/1ps
interface vscale_prng_if #(
  parameter int OUT_WIDTH = 32
);
  logic [1:0]           prng_ctrl;
  logic                 seed_valid;
  logic [63:0]          seed_data;
  logic                 seed_ready;
  logic                 rnd_req;
  logic                 rnd_valid;
  logic [OUT_WIDTH-1:0] rnd_data;
  logic                 warm;

  modport master (
    output prng_ctrl, seed_valid, seed_data, rnd_req,
    input  seed_ready, rnd_valid, rnd_data, warm
  );

  modport slave (
    input  prng_ctrl, seed_valid, seed_data, rnd_req,
    output seed_ready, rnd_valid, rnd_data, warm
  );
endinterface

// File: rtl/vscale_prng.sv
// Masking-randomness source: 64-bit xorshift generator with seed-load
// handshake, warm-up phase and off / free-running / on-demand output modes.
`timescale 1ns/1ps
module vscale_prng #(
  parameter int          OUT_WIDTH    = 32,
  parameter logic [63:0] SEED_DEFAULT = 64'h0000_0000_0000_0001,
  parameter int          WARMUP_STEPS = 16
) (
  input  logic          clk,
  input  logic          reset,
  vscale_prng_if.slave  bus
);

  typedef enum logic [1:0] {
    WARM = 2'd0,
    RUN  = 2'd1,
    SEED = 2'd2
  } fsm_t;

  localparam logic [1:0] CTRL_OFF    = 2'b00;
  localparam logic [1:0] CTRL_FREE   = 2'b01;
  localparam logic [1:0] CTRL_DEMAND = 2'b10;
  localparam logic [1:0] CTRL_RESEED = 2'b11;

  // With no warm-up requested, reset and seed loads go straight to RUN.
  localparam fsm_t       START_STATE = (WARMUP_STEPS == 0) ? RUN : WARM;
  localparam logic [7:0] LAST_WARM   = (WARMUP_STEPS == 0) ? 8'd0 : 8'(WARMUP_STEPS - 1);

  fsm_t        fsm_reg, fsm_next;
  logic [63:0] state_reg, state_next;
  logic [7:0]  warm_cnt_reg, warm_cnt_next;
  logic [1:0]  ctrl_q_reg;
  logic        mode_on;
  logic        seed_entry;
  logic        step_en;

  function automatic logic [63:0] xorshift(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  assign mode_on    = (bus.prng_ctrl == CTRL_FREE) || (bus.prng_ctrl == CTRL_DEMAND);
  // Reseed is edge-triggered on the control field so holding 11 after a
  // completed seed visit does not loop back into SEED.
  assign seed_entry = (bus.prng_ctrl == CTRL_RESEED) && (ctrl_q_reg != CTRL_RESEED);

  // State register: generator state, fsm, warm-up counter, previous control.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg      <= START_STATE;
      state_reg    <= SEED_DEFAULT;
      warm_cnt_reg <= 8'd0;
      ctrl_q_reg   <= CTRL_FREE;
    end else begin
      fsm_reg      <= fsm_next;
      state_reg    <= state_next;
      warm_cnt_reg <= warm_cnt_next;
      ctrl_q_reg   <= bus.prng_ctrl;
    end
  end

  // Next-state logic: step enable, warm-up counting, seed handshake.
  always_comb begin
    fsm_next      = fsm_reg;
    state_next    = state_reg;
    warm_cnt_next = warm_cnt_reg;
    step_en       = 1'b0;
    case (fsm_reg)
      WARM: begin
        if (seed_entry) begin
          fsm_next = SEED;
        end else if (mode_on) begin
          // OFF falls through here, freezing both fsm and counter.
          step_en = 1'b1;
          if (warm_cnt_reg == LAST_WARM) begin
            fsm_next      = RUN;
            warm_cnt_next = 8'd0;
          end else begin
            warm_cnt_next = warm_cnt_reg + 8'd1;
          end
        end
      end
      RUN: begin
        if (seed_entry) begin
          fsm_next = SEED;
        end else if (bus.prng_ctrl == CTRL_FREE) begin
          step_en = 1'b1;
        end else if (bus.prng_ctrl == CTRL_DEMAND && bus.rnd_req) begin
          // rnd_valid is high in RUN/DEMAND, so a request consumes the word.
          step_en = 1'b1;
        end
      end
      SEED: begin
        if (bus.seed_valid) begin
          // An all-zero seed would lock the generator at zero.
          state_next    = (bus.seed_data == 64'd0) ? SEED_DEFAULT : bus.seed_data;
          warm_cnt_next = 8'd0;
          fsm_next      = START_STATE;
        end else if (bus.prng_ctrl != CTRL_RESEED) begin
          fsm_next = RUN;
        end
      end
      default: begin
        fsm_next = START_STATE;
      end
    endcase
    if (step_en) begin
      state_next = xorshift(state_reg);
    end
  end

  // Output decode: word and handshakes from registers plus current mode.
  always_comb begin
    bus.seed_ready = !reset && (fsm_reg == SEED);
    bus.rnd_valid  = !reset && (fsm_reg == RUN) && mode_on;
    bus.rnd_data   = bus.rnd_valid ? state_reg[OUT_WIDTH-1:0] : '0;
    bus.warm       = (fsm_reg == WARM);
  end

endmodule

// File: tb/tb_vscale_prng.sv
// Scoreboard bench for vscale_prng: two instances (no warm-up / 4-step
// warm-up) driven by directed vectors; a negedge monitor pops expectations.
`timescale 1ns/1ps
module tb_vscale_prng;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  vscale_prng_if #(.OUT_WIDTH(32)) if_a ();
  vscale_prng_if #(.OUT_WIDTH(32)) if_b ();

  vscale_prng #(
    .OUT_WIDTH(32), .SEED_DEFAULT(64'h1), .WARMUP_STEPS(0)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave)
  );

  vscale_prng #(
    .OUT_WIDTH(32), .SEED_DEFAULT(64'h1), .WARMUP_STEPS(4)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave)
  );

  typedef struct packed {
    logic        va;
    logic [31:0] da;
    logic        sra;
    logic        cb;
    logic        vb;
    logic [31:0] db;
    logic        srb;
    logic        wb;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] m;
  exp_t        mon_e;
  string       mon_nm;

  function automatic logic [63:0] stp(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  function automatic exp_t ea(input logic v, input logic [31:0] d, input logic sr);
    exp_t e;
    e = '0;
    e.va  = v;
    e.da  = d;
    e.sra = sr;
    return e;
  endfunction

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, required %h", nm, f, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic tick(input logic rst, input logic [1:0] ca, input logic [1:0] cbc,
                      input logic sv, input logic [63:0] sd, input logic req,
                      input exp_t e, input string nm);
    @(posedge clk);
    #1;
    reset             = rst;
    if_a.prng_ctrl    = ca;
    if_a.seed_valid   = sv;
    if_a.seed_data    = sd;
    if_a.rnd_req      = req;
    if_b.prng_ctrl    = cbc;
    exp_q.push_back(e);
    name_q.push_back(nm);
    $display("t=%0t %s ctrl=%b sv=%0d sd=%h req=%0d", $time, nm, ca, sv, sd, req);
  endtask

  // RUN-mode cycle for instance A tracked by the software model state m.
  task automatic run_a(input logic [1:0] c, input logic req, input string nm);
    logic v;
    v = (c == 2'b01) || (c == 2'b10);
    tick(1'b0, c, 2'b01, 1'b0, 64'd0, req, ea(v, v ? m[31:0] : 32'd0, 1'b0), nm);
    if (c == 2'b01 || (c == 2'b10 && req)) m = stp(m);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      chk(mon_nm, "a_valid", 32'(if_a.rnd_valid), 32'(mon_e.va));
      chk(mon_nm, "a_data", if_a.rnd_data, mon_e.da);
      chk(mon_nm, "a_seed_ready", 32'(if_a.seed_ready), 32'(mon_e.sra));
      if (mon_e.cb) begin
        chk(mon_nm, "b_valid", 32'(if_b.rnd_valid), 32'(mon_e.vb));
        chk(mon_nm, "b_data", if_b.rnd_data, mon_e.db);
        chk(mon_nm, "b_seed_ready", 32'(if_b.seed_ready), 32'(mon_e.srb));
        chk(mon_nm, "b_warm", 32'(if_b.warm), 32'(mon_e.wb));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    reset           = 1'b1;
    if_a.prng_ctrl  = 2'b01;
    if_a.seed_valid = 1'b0;
    if_a.seed_data  = 64'd0;
    if_a.rnd_req    = 1'b0;
    if_b.prng_ctrl  = 2'b01;
    if_b.seed_valid = 1'b0;
    if_b.seed_data  = 64'd0;
    if_b.rnd_req    = 1'b0;
    m = 64'h1;

    // Reset: outputs quiet, B sits in WARM.
    for (int i = 0; i < 3; i++) begin
      e = ea(1'b0, 32'd0, 1'b0);
      e.cb = 1'b1; e.wb = 1'b1;
      tick(1'b1, 2'b01, 2'b01, 1'b0, 64'd0, 1'b0, e, "reset");
    end

    // First words after reset; B warms for exactly 4 cycles.
    for (int i = 0; i < 5; i++) begin
      e = ea(1'b1, (i == 0) ? 32'h0000_0001 : (i == 1) ? 32'h4082_2041 : m[31:0], 1'b0);
      e.cb = 1'b1;
      e.vb = (i == 4);
      e.db = (i == 4) ? m[31:0] : 32'd0;
      e.wb = (i != 4);
      tick(1'b0, 2'b01, 2'b01, 1'b0, 64'd0, 1'b0, e, "post_reset");
      m = stp(m);
    end
    for (int i = 0; i < 3; i++) run_a(2'b01, 1'b0, "free");

    // DEMAND: hold, single pulse, burst.
    for (int i = 0; i < 10; i++) run_a(2'b10, 1'b0, "demand_hold");
    run_a(2'b10, 1'b1, "demand_pulse");
    run_a(2'b10, 1'b0, "demand_next");
    for (int i = 0; i < 3; i++) run_a(2'b10, 1'b1, "demand_burst");
    run_a(2'b10, 1'b0, "demand_after");

    // OFF mid-RUN then resume from the retained word.
    for (int i = 0; i < 5; i++) run_a(2'b00, 1'b0, "off");
    run_a(2'b10, 1'b0, "resume");
    for (int i = 0; i < 2; i++) run_a(2'b01, 1'b0, "free2");

    // Zero seed substitutes the default.
    tick(1'b0, 2'b11, 2'b01, 1'b0, 64'd0, 1'b0, ea(1'b0, 32'd0, 1'b0), "seed_entry");
    tick(1'b0, 2'b11, 2'b01, 1'b1, 64'd0, 1'b0, ea(1'b0, 32'd0, 1'b1), "seed_zero_take");
    m = 64'h1;
    run_a(2'b01, 1'b0, "seed_zero_out");
    run_a(2'b01, 1'b0, "seed_zero_out");

    // Held 11 with held seed_valid: only the first seed is taken.
    tick(1'b0, 2'b11, 2'b01, 1'b1, 64'h5, 1'b0, ea(1'b0, 32'd0, 1'b0), "seed5_enter");
    tick(1'b0, 2'b11, 2'b01, 1'b1, 64'h5, 1'b0, ea(1'b0, 32'd0, 1'b1), "seed5_take");
    m = 64'h5;
    tick(1'b0, 2'b11, 2'b01, 1'b1, 64'h9, 1'b0, ea(1'b0, 32'd0, 1'b0), "seed9_reject");
    tick(1'b0, 2'b11, 2'b01, 1'b1, 64'h9, 1'b0, ea(1'b0, 32'd0, 1'b0), "seed9_reject");
    for (int i = 0; i < 3; i++) run_a(2'b01, 1'b0, "seed5_out");

    // Leaving SEED without a seed keeps the state.
    tick(1'b0, 2'b11, 2'b01, 1'b0, 64'd0, 1'b0, ea(1'b0, 32'd0, 1'b0), "abandon_enter");
    tick(1'b0, 2'b01, 2'b01, 1'b0, 64'd0, 1'b0, ea(1'b0, 32'd0, 1'b1), "abandon_leave");
    run_a(2'b01, 1'b0, "abandon_out");

    // Reset while both instances sit in SEED.
    e = ea(1'b0, 32'd0, 1'b0); e.cb = 1'b1;
    tick(1'b0, 2'b11, 2'b11, 1'b0, 64'd0, 1'b0, e, "rst_seed_enter");
    e = ea(1'b0, 32'd0, 1'b1); e.cb = 1'b1; e.srb = 1'b1;
    tick(1'b0, 2'b11, 2'b11, 1'b0, 64'd0, 1'b0, e, "rst_seed_in");
    e = ea(1'b0, 32'd0, 1'b0); e.cb = 1'b1;
    tick(1'b1, 2'b11, 2'b11, 1'b0, 64'd0, 1'b0, e, "rst_seed_assert");
    e = ea(1'b0, 32'd0, 1'b0); e.cb = 1'b1; e.wb = 1'b1;
    tick(1'b1, 2'b01, 2'b01, 1'b0, 64'd0, 1'b0, e, "rst_seed_hold");
    e = ea(1'b1, 32'h0000_0001, 1'b0); e.cb = 1'b1; e.wb = 1'b1;
    tick(1'b0, 2'b01, 2'b01, 1'b0, 64'd0, 1'b0, e, "rst_seed_out");
    tick(1'b0, 2'b01, 2'b01, 1'b0, 64'd0, 1'b0, ea(1'b1, 32'h4082_2041, 1'b0), "rst_seed_out2");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vscale_prng.md
Name: vscale_prng

Overview:
- Masking-randomness source for the domain-oriented-masked datapath.
- Consumes the 2-bit PRNG control field from the CSR file and delivers fresh random words to the masked ALU and other masked consumers.
- Core is a 64-bit xorshift generator with a seed-load handshake, a warm-up phase and three output modes: off, free-running, on-demand.

Parameters:
- OUT_WIDTH, 32: random bits delivered per word; legal range 1..64.
- SEED_DEFAULT, 64'h0000_0000_0000_0001: state loaded at reset and substituted for an all-zero seed; must be nonzero.
- WARMUP_STEPS, 16: generator steps discarded after reset or seed load before output is valid; 0 means no warm-up; legal range 0..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- prng_ctrl  in  2  mode: 00 OFF, 01 FREE, 10 DEMAND, 11 RESEED
- seed_valid  in  1  seed word offered
- seed_data  in  64  seed value
- seed_ready  out  1  seed accepted this cycle when high together with seed_valid
- rnd_req  in  1  consumer takes the current word (DEMAND mode)
- rnd_valid  out  1  rnd_data holds a usable random word
- rnd_data  out  OUT_WIDTH  random word; zero whenever rnd_valid is low
- warm  out  1  high while in WARM

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Registers: state[63:0]; fsm {WARM, RUN, SEED}; warm_cnt[7:0]; ctrl_q[1:0] (previous prng_ctrl).
- Step function (one per cycle when enabled), all 64-bit, shifts zero-fill:
  - x = x ^ (x << 13)
  - x = x ^ (x >> 7)
  - x = x ^ (x << 17)
- Reset (dominates all other inputs):
  - state = SEED_DEFAULT, warm_cnt = 0, ctrl_q = 01.
  - fsm = WARM, or RUN if WARMUP_STEPS == 0.
  - Outputs during and immediately after reset: rnd_valid = 0, rnd_data = 0, seed_ready = 0.
- Step enable:
  - WARM with prng_ctrl in {01, 10}: step every cycle.
  - RUN with 01: step every cycle.
  - RUN with 10: step only when rnd_req && rnd_valid.
  - OFF (00), SEED, or prng_ctrl == 11: no step; state held.
- WARM:
  - Each step increments warm_cnt.
  - The step taken with warm_cnt == WARMUP_STEPS-1 moves fsm to RUN and clears warm_cnt.
  - OFF while in WARM holds both fsm and warm_cnt; warm-up resumes when the mode returns to 01 or 10.
- SEED entry: from WARM or RUN, a cycle with prng_ctrl == 11 && ctrl_q != 11 moves fsm to SEED next cycle. Holding 11 after leaving SEED does not re-enter.
- SEED:
  - seed_ready = 1 (decoded from the fsm register, not from inputs).
  - On seed_valid: state = (seed_data == 0) ? SEED_DEFAULT : seed_data, warm_cnt = 0, fsm = WARM (RUN if WARMUP_STEPS == 0).
  - If prng_ctrl leaves 11 with no seed accepted: fsm = RUN, state unchanged.
  - At most one seed is accepted per SEED visit.
- Output:
  - rnd_valid = (fsm == RUN) && prng_ctrl in {01, 10}; combinational from registers plus prng_ctrl.
  - rnd_data = rnd_valid ? state[OUT_WIDTH-1:0] : 0.
  - A new word appears the cycle after a step.
- DEMAND handshake: a word is consumed on rnd_req && rnd_valid. The same word is never presented after consumption; it is held indefinitely while rnd_req is low.
- Mode change to 00 mid-RUN: rnd_valid drops the same cycle; state is retained; returning to 01 or 10 resumes from the retained state with no warm-up.
- State never reaches zero, because every loaded seed is nonzero.

Test Plan:
- SEED_DEFAULT=1, WARMUP_STEPS=0, OUT_WIDTH=32, ctrl=01, release reset -> first cycle after reset rnd_valid=1, rnd_data=0x00000001; next cycle rnd_data=0x40822041; following cycles match the 64-bit software model.
- WARMUP_STEPS=4, ctrl=01, reset -> rnd_valid=0 and warm=1 for exactly 4 cycles; 5th cycle rnd_valid=1, rnd_data = low 32 bits of step^4(1).
- ctrl=10 in RUN, rnd_req=0 for 10 cycles -> rnd_data held constant; pulse rnd_req for 1 cycle -> next cycle shows the next step value; rnd_req=1 for 3 cycles -> 3 distinct consecutive sequence values.
- ctrl 01->11, seed_valid=1 with seed_data=0 -> seed_ready=1 one cycle after entry; state loaded with SEED_DEFAULT; with WARMUP_STEPS=0 and ctrl back to 01, rnd_data=0x00000001.
- ctrl held 11, seed_valid held 1 with seed 0x5 then 0x9 -> only 0x5 accepted; seed_ready high for exactly one cycle; after return to 01 the output sequence starts from 0x5.
- ctrl=00 mid-RUN for 5 cycles, then 01 -> rnd_valid=0 and rnd_data=0 during OFF; on resume rnd_data equals the value shown before OFF; reset asserted in SEED -> fsm=WARM, seed_ready=0, state=SEED_DEFAULT.
